// File: rtl/divider_prog.sv
// Programmable integer clock divider: runtime-loadable divisor applied only at
// period boundaries, with near-50% clk_out, a last-cycle tick and a load handshake.
module divider_prog #(
  parameter int unsigned      CNT_W       = 8,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(6)
) (
  input  logic             sys_clock,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             load_ack,
  output logic             load_err,
  output logic             div_pend,
  output logic [CNT_W-1:0] div_act
);

  if (DIV_DEFAULT < CNT_W'(2)) begin : g_bad_default
    $error("divider_prog: DIV_DEFAULT must be >= 2");
  end

  logic             run_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] pend_reg;
  logic             pend_v_reg;

  logic             run_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] pend_next;
  logic             pend_v_next;
  logic [CNT_W-1:0] div_act_next;
  logic             load_ack_next;
  logic             load_err_next;
  logic             clk_out_next;
  logic             tick_next;
  logic             last_cnt;
  logic             boundary;
  logic             div_valid;

  always_comb begin
    last_cnt      = (cnt_reg == (div_act - 1'b1));
    boundary      = !en || !run_reg || last_cnt;
    div_valid     = (div_in >= CNT_W'(2));
    run_next      = en;
    cnt_next      = '0;
    pend_next     = pend_reg;
    pend_v_next   = pend_v_reg;
    div_act_next  = div_act;
    load_ack_next = 1'b0;
    load_err_next = div_load && !div_valid;

    if (en && run_reg && !last_cnt) begin
      cnt_next = cnt_reg + 1'b1;
    end

    // A fresh valid load beats a stale pending value, both at a boundary and not.
    if (div_load && div_valid) begin
      if (boundary) begin
        div_act_next  = div_in;
        pend_v_next   = 1'b0;
        load_ack_next = 1'b1;
      end else begin
        pend_next   = div_in;
        pend_v_next = 1'b1;
      end
    end else if (boundary && pend_v_reg) begin
      div_act_next  = pend_reg;
      pend_v_next   = 1'b0;
      load_ack_next = 1'b1;
    end

    clk_out_next = run_next && (cnt_next < (div_act_next >> 1));
    tick_next    = run_next && (cnt_next == (div_act_next - 1'b1));
  end

  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_reg    <= 1'b0;
      cnt_reg    <= '0;
      pend_reg   <= '0;
      pend_v_reg <= 1'b0;
      div_act    <= DIV_DEFAULT;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
      div_pend   <= 1'b0;
    end else begin
      run_reg    <= run_next;
      cnt_reg    <= cnt_next;
      pend_reg   <= pend_next;
      pend_v_reg <= pend_v_next;
      div_act    <= div_act_next;
      clk_out    <= clk_out_next;
      tick       <= tick_next;
      load_ack   <= load_ack_next;
      load_err   <= load_err_next;
      div_pend   <= pend_v_next;
    end
  end

endmodule
